// File: rtl/data_path_pkg.sv
// Shared data-path definitions: checker FSM encoding, word size and default counter step.
package data_path_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SEED  = 2'd2,
    CHECK = 2'd3
  } chk_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [31:0] DEFAULT_STEP   = 32'd1;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_bufr,
  input  logic         data_path_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_bufr or posedge data_path_rst) begin
    if (data_path_rst) count_q <= '0;
    else               count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/counter_pattern_checker.sv
// Drains the host-to-card FIFO and checks for an incrementing counter pattern.
// Optional first-error capture ports are enabled by defining PATTERN_CHK_ERR_CAPTURE_EN.
//   state | meaning
//   IDLE  | disabled, waiting for chk_en
//   ARM   | one cycle: load explicit seed or go fetch one
//   SEED  | one read outstanding, first word becomes the seed
//   CHECK | compare every returned word against expected
module counter_pattern_checker
  import data_path_pkg::*;
#(
  parameter logic [31:0] STEP  = DEFAULT_STEP,
  parameter int          ERR_W = 32
) (
  input  logic             clk_bufr,
  input  logic             data_path_rst,
  input  logic             chk_en,
  input  logic             cnt_clr,
  input  logic             seed_mode,
  input  logic [31:0]      seed_value,
  input  logic [31:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [63:0]      byte_count,
  output logic [ERR_W-1:0] err_count,
  output logic             locked,
  output logic [1:0]       chk_state
`ifdef PATTERN_CHK_ERR_CAPTURE_EN
  ,
  output logic [31:0]      first_err_exp,
  output logic [31:0]      first_err_got,
  output logic             first_err_valid
`endif
);

  chk_state_e  state_q, state_d;
  logic [31:0] expected_q, expected_d;
  logic [63:0] byte_count_q, byte_count_d;
  logic        locked_q, locked_d;
  logic        rd_v_q;
  logic        seed_pending_q, seed_pending_d;
  logic        mismatch;

  always_comb begin
    fifo_rd_en     = ((state_q == SEED) || (state_q == CHECK)) && chk_en &&
                     !fifo_empty && !seed_pending_q;
    state_d        = state_q;
    expected_d     = expected_q;
    byte_count_d   = byte_count_q;
    locked_d       = locked_q;
    seed_pending_d = seed_pending_q;
    mismatch       = 1'b0;

    // Returned words are processed regardless of state so a word in flight at chk_en fall still counts.
    if (rd_v_q) begin
      byte_count_d = byte_count_q + 64'(BYTES_PER_WORD);
      if (seed_pending_q) begin
        expected_d     = fifo_dout + STEP;
        seed_pending_d = 1'b0;
      end else begin
        mismatch   = (fifo_dout != expected_q);
        expected_d = mismatch ? (fifo_dout + STEP) : (expected_q + STEP);
      end
    end

    if (fifo_rd_en && (state_q == SEED)) seed_pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        locked_d = 1'b0;
        if (chk_en) state_d = ARM;
      end
      ARM: begin
        if (!chk_en) begin
          state_d = IDLE;
        end else if (!seed_mode) begin
          expected_d = seed_value;
          locked_d   = 1'b1;
          state_d    = CHECK;
        end else begin
          state_d = SEED;
        end
      end
      SEED: begin
        if (!chk_en) begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end else if (rd_v_q && seed_pending_q) begin
          locked_d = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (!chk_en) begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cnt_clr) byte_count_d = '0;
  end

  always_ff @(posedge clk_bufr or posedge data_path_rst) begin
    if (data_path_rst) begin
      state_q        <= IDLE;
      expected_q     <= '0;
      byte_count_q   <= '0;
      locked_q       <= 1'b0;
      rd_v_q         <= 1'b0;
      seed_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      byte_count_q   <= byte_count_d;
      locked_q       <= locked_d;
      rd_v_q         <= fifo_rd_en;
      seed_pending_q <= seed_pending_d;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk_bufr      (clk_bufr),
    .data_path_rst (data_path_rst),
    .clr           (cnt_clr),
    .inc           (mismatch),
    .count         (err_count)
  );

  assign byte_count = byte_count_q;
  assign locked     = locked_q;
  assign chk_state  = state_q;

`ifdef PATTERN_CHK_ERR_CAPTURE_EN
  logic [31:0] first_err_exp_q, first_err_exp_d;
  logic [31:0] first_err_got_q, first_err_got_d;
  logic        first_err_valid_q, first_err_valid_d;

  always_comb begin
    first_err_exp_d   = first_err_exp_q;
    first_err_got_d   = first_err_got_q;
    first_err_valid_d = first_err_valid_q;
    if (cnt_clr) begin
      first_err_exp_d   = '0;
      first_err_got_d   = '0;
      first_err_valid_d = 1'b0;
    end else if (mismatch && !first_err_valid_q) begin
      first_err_exp_d   = expected_q;
      first_err_got_d   = fifo_dout;
      first_err_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_bufr or posedge data_path_rst) begin
    if (data_path_rst) begin
      first_err_exp_q   <= '0;
      first_err_got_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      first_err_exp_q   <= first_err_exp_d;
      first_err_got_q   <= first_err_got_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign first_err_exp   = first_err_exp_q;
  assign first_err_got   = first_err_got_q;
  assign first_err_valid = first_err_valid_q;
`endif

endmodule

// File: tb/tb_counter_pattern_checker.sv
// Directed bench for counter_pattern_checker with a behavioural FIFO (1-cycle read latency).
module tb_counter_pattern_checker;

  localparam int ERR_W = 4;

  logic             clk_bufr;
  logic             data_path_rst;
  logic             chk_en;
  logic             cnt_clr;
  logic             seed_mode;
  logic [31:0]      seed_value;
  logic [31:0]      fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [63:0]      byte_count;
  logic [ERR_W-1:0] err_count;
  logic             locked;
  logic [1:0]       chk_state;
`ifdef PATTERN_CHK_ERR_CAPTURE_EN
  logic [31:0]      first_err_exp;
  logic [31:0]      first_err_got;
  logic             first_err_valid;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   viol   = 0;
  logic flush       = 1'b0;
  logic toggle_en   = 1'b0;
  logic empty_force = 1'b0;

  counter_pattern_checker #(.STEP(32'd1), .ERR_W(ERR_W)) dut (
    .clk_bufr        (clk_bufr),
    .data_path_rst   (data_path_rst),
    .chk_en          (chk_en),
    .cnt_clr         (cnt_clr),
    .seed_mode       (seed_mode),
    .seed_value      (seed_value),
    .fifo_dout       (fifo_dout),
    .fifo_empty      (fifo_empty),
    .fifo_rd_en      (fifo_rd_en),
    .byte_count      (byte_count),
    .err_count       (err_count),
    .locked          (locked),
    .chk_state       (chk_state)
`ifdef PATTERN_CHK_ERR_CAPTURE_EN
    ,
    .first_err_exp   (first_err_exp),
    .first_err_got   (first_err_got),
    .first_err_valid (first_err_valid)
`endif
  );

  initial clk_bufr = 1'b0;
  always #5 clk_bufr = ~clk_bufr;

  assign fifo_empty = (rd_ptr == wr_ptr) || empty_force;

  always @(posedge clk_bufr) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(posedge clk_bufr) empty_force <= toggle_en ? ~empty_force : 1'b0;

  always @(negedge clk_bufr) if (fifo_rd_en && fifo_empty) viol = viol + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_bufr);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_drain(input int budget, output int cycles);
    cycles = 0;
    while ((rd_ptr != wr_ptr) && (cycles < budget)) begin
      tick(1);
      cycles++;
    end
    vectors++;
    if (rd_ptr != wr_ptr) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words left, required 0", wr_ptr - rd_ptr);
    end
    tick(3);
  endtask

  task automatic stop_and_flush();
    chk_en = 1'b0;
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    data_path_rst = 1'b1;
    tick(2);
    vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
    vectors++; if (byte_count !== 64'd0) begin miscompares++; $display("FAIL rst_byte_count: got %0d want 0", byte_count); end
    vectors++; if (err_count !== '0) begin miscompares++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_locked: got %b want 0", locked); end
    vectors++; if (chk_state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", chk_state); end
    data_path_rst = 1'b0;
    tick(2);
    vectors++; if (chk_state !== 2'd0) begin miscompares++; $display("FAIL post_rst_state: got %0d want 0", chk_state); end
  endtask

  task automatic test_seed_stream();
    int cyc;
    seed_mode = 1'b1;
    for (int i = 0; i < 256; i++) push(32'h10 + 32'(i));
    chk_en = 1'b1;
    wait_drain(1000, cyc);
    vectors++; if (cyc > 260) begin miscompares++; $display("FAIL seed_throughput: got %0d cycles want <= 260", cyc); end
    vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL seed_err_count: got %0d want 0", err_count); end
    vectors++; if (byte_count !== 64'd1024) begin miscompares++; $display("FAIL seed_byte_count: got %0d want 1024", byte_count); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL seed_locked: got %b want 1", locked); end
    vectors++; if (chk_state !== 2'd3) begin miscompares++; $display("FAIL seed_state: got %0d want 3", chk_state); end
    stop_and_flush();
    pulse_clr();
  endtask

  task automatic test_explicit_seed();
    int cyc;
    seed_mode  = 1'b0;
    seed_value = 32'd5;
    push(32'd5); push(32'd6); push(32'd8); push(32'd9);
    chk_en = 1'b1;
    wait_drain(100, cyc);
    vectors++; if (err_count !== 4'd1) begin miscompares++; $display("FAIL expl_err_count: got %0d want 1", err_count); end
    vectors++; if (byte_count !== 64'd16) begin miscompares++; $display("FAIL expl_byte_count: got %0d want 16", byte_count); end
`ifdef PATTERN_CHK_ERR_CAPTURE_EN
    vectors++; if (first_err_exp !== 32'd7) begin miscompares++; $display("FAIL expl_cap_exp: got %0d want 7", first_err_exp); end
    vectors++; if (first_err_got !== 32'd8) begin miscompares++; $display("FAIL expl_cap_got: got %0d want 8", first_err_got); end
    vectors++; if (first_err_valid !== 1'b1) begin miscompares++; $display("FAIL expl_cap_valid: got %b want 1", first_err_valid); end
`endif
    stop_and_flush();
    pulse_clr();
  endtask

  task automatic test_wrap();
    int cyc;
    seed_mode  = 1'b0;
    seed_value = 32'hFFFF_FFFE;
    push(32'hFFFF_FFFE); push(32'hFFFF_FFFF); push(32'h0); push(32'h1);
    chk_en = 1'b1;
    wait_drain(100, cyc);
    vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL wrap_err_count: got %0d want 0", err_count); end
    vectors++; if (byte_count !== 64'd16) begin miscompares++; $display("FAIL wrap_byte_count: got %0d want 16", byte_count); end
    stop_and_flush();
    pulse_clr();
  endtask

  task automatic test_empty_toggle();
    int cyc;
    int viol_start;
    seed_mode  = 1'b1;
    for (int i = 0; i < 100; i++) push(32'h1000 + 32'(i));
    viol_start = viol;
    toggle_en  = 1'b1;
    chk_en     = 1'b1;
    wait_drain(1000, cyc);
    toggle_en = 1'b0;
    tick(2);
    vectors++; if (viol !== viol_start) begin miscompares++; $display("FAIL tog_rd_while_empty: got %0d cycles want 0", viol - viol_start); end
    vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL tog_err_count: got %0d want 0", err_count); end
    vectors++; if (byte_count !== 64'd400) begin miscompares++; $display("FAIL tog_byte_count: got %0d want 400", byte_count); end
    stop_and_flush();
    pulse_clr();
  endtask

  task automatic test_saturate();
    int cyc;
    seed_mode  = 1'b0;
    seed_value = 32'd0;
    for (int i = 0; i < 20; i++) push(32'd0);
    chk_en = 1'b1;
    wait_drain(200, cyc);
    vectors++; if (err_count !== 4'd15) begin miscompares++; $display("FAIL sat_err_count: got %0d want 15", err_count); end
    vectors++; if (byte_count !== 64'd80) begin miscompares++; $display("FAIL sat_byte_count: got %0d want 80", byte_count); end
`ifdef PATTERN_CHK_ERR_CAPTURE_EN
    vectors++; if (first_err_exp !== 32'd1) begin miscompares++; $display("FAIL sat_cap_exp: got %0d want 1", first_err_exp); end
    vectors++; if (first_err_got !== 32'd0) begin miscompares++; $display("FAIL sat_cap_got: got %0d want 0", first_err_got); end
`endif
    stop_and_flush();
  endtask

  task automatic test_chk_en_drop();
    int start;
    int n;
    seed_mode  = 1'b0;
    seed_value = 32'h100;
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
    start  = rd_ptr;
    chk_en = 1'b1;
    n = 0;
    while ((rd_ptr == start) && (n < 20)) begin tick(1); n++; end
    chk_en = 1'b0;
    #1;
    vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL drop_rd_en: got %b want 0", fifo_rd_en); end
    tick(2);
    vectors++; if ((rd_ptr - start) !== 1) begin miscompares++; $display("FAIL drop_words_read: got %0d want 1", rd_ptr - start); end
    vectors++; if (byte_count !== 64'd84) begin miscompares++; $display("FAIL drop_byte_count: got %0d want 84", byte_count); end
    vectors++; if (err_count !== 4'd15) begin miscompares++; $display("FAIL drop_err_hold: got %0d want 15", err_count); end
    vectors++; if (chk_state !== 2'd0) begin miscompares++; $display("FAIL drop_state: got %0d want 0", chk_state); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL drop_locked: got %b want 0", locked); end
    pulse_clr();
    vectors++; if (byte_count !== 64'd0) begin miscompares++; $display("FAIL clr_byte_count: got %0d want 0", byte_count); end
    vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL clr_err_count: got %0d want 0", err_count); end
`ifdef PATTERN_CHK_ERR_CAPTURE_EN
    vectors++; if (first_err_valid !== 1'b0) begin miscompares++; $display("FAIL clr_cap_valid: got %b want 0", first_err_valid); end
    vectors++; if (first_err_exp !== 32'd0) begin miscompares++; $display("FAIL clr_cap_exp: got %0d want 0", first_err_exp); end
`endif
    stop_and_flush();
  endtask

  task automatic test_reset_mid_check();
    int cyc;
    int remaining;
    seed_mode = 1'b1;
    for (int i = 0; i < 50; i++) push(32'h5000 + 32'(i));
    chk_en = 1'b1;
    tick(20);
    vectors++; if (byte_count === 64'd0) begin miscompares++; $display("FAIL mid_progress: got byte_count 0 want nonzero"); end
    #3;
    data_path_rst = 1'b1;
    #1;
    vectors++; if (byte_count !== 64'd0) begin miscompares++; $display("FAIL mid_rst_byte_count: got %0d want 0", byte_count); end
    vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL mid_rst_err_count: got %0d want 0", err_count); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL mid_rst_locked: got %b want 0", locked); end
    vectors++; if (chk_state !== 2'd0) begin miscompares++; $display("FAIL mid_rst_state: got %0d want 0", chk_state); end
    vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rd_en: got %b want 0", fifo_rd_en); end
    chk_en = 1'b0;
    tick(2);
    data_path_rst = 1'b0;
    tick(1);
    remaining = wr_ptr - rd_ptr;
    chk_en = 1'b1;
    wait_drain(200, cyc);
    vectors++; if (err_count !== 4'd0) begin miscompares++; $display("FAIL reseed_err_count: got %0d want 0", err_count); end
    vectors++; if (byte_count !== 64'(4 * remaining)) begin miscompares++; $display("FAIL reseed_byte_count: got %0d want %0d", byte_count, 4 * remaining); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL reseed_locked: got %b want 1", locked); end
    vectors++; if (chk_state !== 2'd3) begin miscompares++; $display("FAIL reseed_state: got %0d want 3", chk_state); end
    stop_and_flush();
  endtask

  initial begin
    data_path_rst = 1'b1;
    chk_en        = 1'b0;
    cnt_clr       = 1'b0;
    seed_mode     = 1'b0;
    seed_value    = 32'd0;
    test_reset();
    test_seed_stream();
    test_explicit_seed();
    test_wrap();
    test_empty_toggle();
    test_saturate();
    test_chk_en_drop();
    test_reset_mid_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/counter_pattern_checker.md
Name: counter_pattern_checker

Overview:
- Receive-side counterpart of the data path's counter test-pattern generator.
- Drains 32-bit words from the host-to-card DMA FIFO (written on clk_pcie, read on clk_bufr) and checks that they form an incrementing counter sequence.
- Reports byte count, mismatch count and lock/state to the register file, so the full PCIe/DDR3 loop is verified in hardware without an ADC.

Parameters:
- STEP, 1, increment between consecutive expected words (mod 2^32)
- ERR_W, 32, width of the saturating error counter

Ports:
- clk_bufr  in  1  checker clock (pcie clock divided by 2)
- data_path_rst  in  1  asynchronous, active-high reset
- chk_en  in  1  check enable (control register bit, already synchronised)
- cnt_clr  in  1  synchronous clear of byte_count/err_count (manual reset bit)
- seed_mode  in  1  1 = take seed from first received word; 0 = use seed_value
- seed_value  in  32  explicit first expected word when seed_mode=0
- fifo_dout  in  32  FIFO read data, valid one cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe
- byte_count  out  64  bytes checked (+4 per word)
- err_count  out  ERR_W  mismatching words
- locked  out  1  expected value established, checking active
- chk_state  out  2  FSM state encoding for debug readback

Behaviour:
- Reset (async, data_path_rst high): state=IDLE, fifo_rd_en=0, byte_count=0, err_count=0, locked=0, expected=0, valid pipe=0, chk_state=0.
- Read handshake: fifo_rd_en = (state==SEED or CHECK) & chk_en & !fifo_empty & !seed_pending. fifo_rd_en never asserts while fifo_empty=1. A registered copy rd_v marks fifo_dout valid on the next cycle (latency 1).
- FSM states (chk_state encoding): IDLE=0, ARM=1, SEED=2, CHECK=3.
- IDLE -> ARM when chk_en=1.
- ARM (one cycle): if seed_mode=0, expected<=seed_value, locked<=1, go to CHECK. Otherwise go to SEED.
- SEED: issue exactly one read; seed_pending blocks further reads until data returns. On rd_v: expected<=fifo_dout+STEP, locked<=1, byte_count+=4 (not checked), go to CHECK.
- CHECK, on each rd_v:
  - fifo_dout==expected: expected<=expected+STEP.
  - fifo_dout!=expected: err_count+=1, expected<=fifo_dout+STEP (resync, so one dropped word yields exactly one error).
  - byte_count+=4 either way.
- chk_en falling in any state: fifo_rd_en drops the same cycle (combinational gating). A word already in flight (rd_v next cycle) is still checked and counted. Then state<=IDLE and locked<=0; byte_count and err_count hold.
- cnt_clr=1: byte_count and err_count are zeroed; it has priority over an increment in the same cycle. FSM and expected are unaffected.
- Arithmetic:
  - expected wraps mod 2^32 (0xFFFFFFFF+1 -> 0, not an error).
  - byte_count wraps mod 2^64.
  - err_count saturates at all-ones.
- Throughput: one word per clock sustained while the FIFO is non-empty.

Optional Feature:
- Macro: PATTERN_CHK_ERR_CAPTURE_EN.
- Defined: adds outputs first_err_exp[31:0] and first_err_got[31:0], plus first_err_valid.
  - On the first mismatch after reset or cnt_clr, latch the expected and received values and set first_err_valid=1.
  - Later errors do not overwrite the capture.
  - cnt_clr and reset clear all three outputs to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package data_path_pkg holds:
  - FSM state localparams (IDLE/ARM/SEED/CHECK, 2-bit)
  - BYTES_PER_WORD=4
  - default STEP
- A sub-module is natural for the error counter: sat_counter (width-parameterised, with clear, increment and saturate). It is also reusable for overflow counters elsewhere in the data path.

Test Plan:
- seed_mode=1, FIFO supplies 0x00000010..0x0000010F (256 words) with chk_en=1 -> err_count=0, byte_count=1024, locked=1, chk_state=3.
- seed_mode=0, seed_value=5, stream 5,6,8,9 -> err_count=1 (at 8, resync), byte_count=16; with capture macro: first_err_exp=7, first_err_got=8.
- Wrap: seed 0xFFFFFFFE, stream 0xFFFFFFFE,0xFFFFFFFF,0,1 -> err_count=0, byte_count=16.
- FIFO empty toggled every other cycle during a 100-word stream -> fifo_rd_en never high while fifo_empty=1; err_count=0, byte_count=400.
- chk_en dropped the cycle after a read -> that word is still counted (byte_count+4), fifo_rd_en=0 immediately, state=IDLE, locked=0; cnt_clr pulse -> byte_count=0, err_count=0.
- data_path_rst asserted mid-CHECK -> all outputs return to reset values asynchronously; after release plus chk_en, re-seed succeeds with err_count=0.
